// File: rtl/dda_step_ctrl.sv
// dda_step_ctrl: run sequencer for the posit DDA spring-mass solver.
// Latches a run configuration, loads the integrators, then issues one Euler step at a
// time. After each load or step it waits SETTLE cycles for the combinational posit
// datapath, then presents the resulting (v1,v2) state on a valid/ready sample port.
// Optional feature: define DDA_CTRL_DECIM_EN to add the decim port (sample decimation).
module dda_step_ctrl #(
    parameter int unsigned N      = 16,
    parameter int unsigned ES     = 2,
    parameter int unsigned SW     = 16,
    parameter int unsigned SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [SW-1:0] num_steps,
    input  logic [N-1:0]  cfg_ic1,
    input  logic [N-1:0]  cfg_ic2,
    input  logic [N-1:0]  cfg_kM,
    input  logic [N-1:0]  cfg_dM,
    input  logic [N-1:0]  cfg_dt,
`ifdef DDA_CTRL_DECIM_EN
    input  logic [7:0]    decim,
`endif
    output logic          dda_en,
    output logic          dda_rst_n,
    output logic [N-1:0]  dda_ic1,
    output logic [N-1:0]  dda_ic2,
    output logic [N-1:0]  dda_vK_M,
    output logic [N-1:0]  dda_vD_M,
    output logic [N-1:0]  dda_dt,
    input  logic [N-1:0]  v1,
    input  logic [N-1:0]  v2,
    output logic          smp_valid,
    input  logic          smp_ready,
    output logic [N-1:0]  smp_v1,
    output logic [N-1:0]  smp_v2,
    output logic [SW-1:0] smp_idx,
    output logic          busy,
    output logic          done
);

    // ES only tags the posit format being driven; it does not affect the settle counter.
    localparam int unsigned CW = ((SETTLE > 1) ? $clog2(SETTLE) : 1) + (ES * 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;

    logic [2:0]    state, state_d;
    logic [SW-1:0] num_steps_q, num_steps_d;
    logic [SW-1:0] step_cnt, step_cnt_d;
    logic [CW-1:0] settle_cnt, settle_cnt_d;
    logic          dda_en_d, dda_rst_n_d;
    logic [N-1:0]  ic1_d, ic2_d, vk_d, vd_d, dt_d;
    logic          smp_valid_d;
    logic [N-1:0]  smp_v1_d, smp_v2_d;
    logic [SW-1:0] smp_idx_d;
    logic          busy_d, done_d;
    logic          emit_ok;
`ifdef DDA_CTRL_DECIM_EN
    logic [7:0]    decim_q, decim_d;
    logic [7:0]    decim_cnt, decim_cnt_d;
`endif

    // State register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            num_steps_q <= '0;
            step_cnt    <= '0;
            settle_cnt  <= '0;
            dda_en      <= 1'b0;
            dda_rst_n   <= 1'b1;
            dda_ic1     <= '0;
            dda_ic2     <= '0;
            dda_vK_M    <= '0;
            dda_vD_M    <= '0;
            dda_dt      <= '0;
            smp_valid   <= 1'b0;
            smp_v1      <= '0;
            smp_v2      <= '0;
            smp_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef DDA_CTRL_DECIM_EN
            decim_q     <= '0;
            decim_cnt   <= '0;
`endif
        end else begin
            state       <= state_d;
            num_steps_q <= num_steps_d;
            step_cnt    <= step_cnt_d;
            settle_cnt  <= settle_cnt_d;
            dda_en      <= dda_en_d;
            dda_rst_n   <= dda_rst_n_d;
            dda_ic1     <= ic1_d;
            dda_ic2     <= ic2_d;
            dda_vK_M    <= vk_d;
            dda_vD_M    <= vd_d;
            dda_dt      <= dt_d;
            smp_valid   <= smp_valid_d;
            smp_v1      <= smp_v1_d;
            smp_v2      <= smp_v2_d;
            smp_idx     <= smp_idx_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef DDA_CTRL_DECIM_EN
            decim_q     <= decim_d;
            decim_cnt   <= decim_cnt_d;
`endif
        end
    end

    // Next-state and next-output logic; outputs are derived from the next state
    always_comb begin
        state_d      = state;
        num_steps_d  = num_steps_q;
        step_cnt_d   = step_cnt;
        settle_cnt_d = settle_cnt;
        dda_en_d     = 1'b0;
        dda_rst_n_d  = 1'b1;
        ic1_d        = dda_ic1;
        ic2_d        = dda_ic2;
        vk_d         = dda_vK_M;
        vd_d         = dda_vD_M;
        dt_d         = dda_dt;
        smp_valid_d  = smp_valid;
        smp_v1_d     = smp_v1;
        smp_v2_d     = smp_v2;
        smp_idx_d    = smp_idx;
        busy_d       = 1'b0;
        done_d       = 1'b0;
`ifdef DDA_CTRL_DECIM_EN
        decim_d      = decim_q;
        decim_cnt_d  = decim_cnt;
        // decim_cnt tracks step_cnt modulo (decim+1); the final step always emits
        emit_ok      = (decim_cnt == 8'd0) || (step_cnt == num_steps_q);
`else
        emit_ok      = 1'b1;
`endif

        if (abort) begin
            state_d     = S_IDLE;
            smp_valid_d = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ic1_d       = cfg_ic1;
                        ic2_d       = cfg_ic2;
                        vk_d        = cfg_kM;
                        vd_d        = cfg_dM;
                        dt_d        = cfg_dt;
                        num_steps_d = num_steps;
                        step_cnt_d  = '0;
`ifdef DDA_CTRL_DECIM_EN
                        decim_d     = decim;
                        decim_cnt_d = 8'd0;
`endif
                        state_d     = S_LOAD;
                    end
                end
                S_LOAD: begin
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == CW'(SETTLE - 1)) begin
                        settle_cnt_d = '0;
                        if (emit_ok) begin
                            smp_v1_d    = v1;
                            smp_v2_d    = v2;
                            smp_idx_d   = step_cnt;
                            smp_valid_d = 1'b1;
                            state_d     = S_EMIT;
                        end else begin
                            state_d = S_STEP;
                        end
                    end else begin
                        settle_cnt_d = settle_cnt + CW'(1);
                    end
                end
                S_EMIT: begin
                    if (smp_ready) begin
                        smp_valid_d = 1'b0;
                        if (step_cnt == num_steps_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    step_cnt_d   = step_cnt + SW'(1);
                    settle_cnt_d = '0;
`ifdef DDA_CTRL_DECIM_EN
                    decim_cnt_d  = (decim_cnt == decim_q) ? 8'd0 : decim_cnt + 8'd1;
`endif
                    state_d      = S_SETTLE;
                end
                default: begin
                    state_d     = S_IDLE;
                    smp_valid_d = 1'b0;
                end
            endcase
        end

        // Integrator strobes exist only while in LOAD or STEP
        dda_en_d    = (state_d == S_LOAD) || (state_d == S_STEP);
        dda_rst_n_d = (state_d != S_LOAD);
        busy_d      = (state_d != S_IDLE);
    end

endmodule
